// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, ALU ops, cmds, conditions.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALUOP_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   // FSM states
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;

   // ALU operation encodings (zero-extended onto ALUControl)
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd4;

   // Data-processing cmd field, Funct[4:1]
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // True for the data-processing commands this controller executes
   function automatic logic cmd_supported(input logic [3:0] cmd);
      case (cmd)
         CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Map a data-processing cmd onto its ALU operation
   function automatic logic [ALUOP_W-1:0] cmd_to_alu(input logic [3:0] cmd);
      case (cmd)
         CMD_SUB, CMD_CMP: return ALU_SUB;
         CMD_AND:          return ALU_AND;
         CMD_ORR:          return ALU_ORR;
         CMD_EOR:          return ALU_EOR;
         default:          return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against stored {N,Z,C,V}.
module cond_eval
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex_c
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   // Evaluate condition field
   always_comb begin
      cond_ex_c = 1'b0;
      case (cond)
         COND_EQ: cond_ex_c = z;
         COND_NE: cond_ex_c = ~z;
         COND_CS: cond_ex_c = c;
         COND_CC: cond_ex_c = ~c;
         COND_MI: cond_ex_c = n;
         COND_PL: cond_ex_c = ~n;
         COND_VS: cond_ex_c = v;
         COND_VC: cond_ex_c = ~v;
         COND_HI: cond_ex_c = c & ~z;
         COND_LS: cond_ex_c = ~c | z;
         COND_GE: cond_ex_c = (n == v);
         COND_LT: cond_ex_c = (n != v);
         COND_GT: cond_ex_c = ~z & (n == v);
         COND_LE: cond_ex_c = z | (n != v);
         COND_AL: cond_ex_c = 1'b1;
         COND_NV: cond_ex_c = 1'b0;
         default: cond_ex_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main FSM, ALU decode, flag and condition state.
module mc_controller
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 3
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          Instr,
   input  logic [3:0]           ALUFlags,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic                 AdrSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 Illegal
);

   state_t             state, next_state;
   logic [3:0]         flags;
   logic               cond_ex_reg;
   logic               cond_ex;

   logic [3:0]         cond;
   logic [1:0]         op;
   logic [5:0]         funct;
   logic [3:0]         cmd;
   logic [3:0]         rd;
   logic               is_cmp, is_arith, legal;
   logic [1:0]         flag_w;
   logic [ALUOP_W-1:0] alu_sel;
   logic               pc_we, ir_we, reg_we, mem_we;
   logic               unused_instr_bits;

   assign cond  = Instr[31:28];
   assign op    = Instr[27:26];
   assign funct = Instr[25:20];
   assign rd    = Instr[15:12];
   assign cmd   = funct[4:1];
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};

   assign is_cmp   = (cmd == CMD_CMP);
   assign is_arith = (cmd == CMD_ADD) | (cmd == CMD_SUB) | is_cmp;
   assign legal    = (op == 2'b01) | (op == 2'b10) | ((op == 2'b00) & cmd_supported(cmd));

   cond_eval u_cond_eval (
      .cond      (cond),
      .flags     (flags),
      .cond_ex_c (cond_ex)
   );

   // Flag write mask from S bit and operation class
   always_comb begin
      flag_w = 2'b00;
      if (is_cmp)
         flag_w = 2'b11;
      else if (funct[0])
         flag_w = is_arith ? 2'b11 : 2'b10;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Condition latch in DECODE; flags captured at end of an executed data-processing cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags       <= 4'b0000;
         cond_ex_reg <= 1'b0;
      end else begin
         if (state == S_DECODE)
            cond_ex_reg <= cond_ex;
         if (((state == S_EXECR) || (state == S_EXECI)) && cond_ex_reg) begin
            if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Next-state and datapath control
   always_comb begin
      next_state = state;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      alu_sel    = ALU_ADD;
      Illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (MemReady) begin
               pc_we      = 1'b1;
               ir_we      = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (!legal) begin
               Illegal    = 1'b1;
               next_state = S_FETCH;
            end else if (op == 2'b01)
               next_state = S_MEMADR;
            else if (op == 2'b10)
               next_state = S_BRANCH;
            else
               next_state = funct[5] ? S_EXECI : S_EXECR;
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            next_state = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc = 1'b1;
            if (MemReady) next_state = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            reg_we     = cond_ex_reg;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            mem_we = cond_ex_reg;
            if (MemReady) next_state = S_FETCH;
         end
         S_EXECR: begin
            alu_sel    = cmd_to_alu(cmd);
            next_state = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            alu_sel    = cmd_to_alu(cmd);
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            if (rd == 4'd15) pc_we  = cond_ex_reg & ~is_cmp;
            else             reg_we = cond_ex_reg & ~is_cmp;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            pc_we      = cond_ex_reg;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
   end

   assign ALUControl = ALUCTRL_W'(alu_sel);

   // Write enables are suppressed for as long as reset is held
   assign PCWrite  = pc_we  & ~reset;
   assign IRWrite  = ir_we  & ~reset;
   assign RegWrite = reg_we & ~reset;
   assign MemWrite = mem_we & ~reset;

endmodule
